// File: rtl/pong_match_ctrl_pkg.sv
// Shared definitions for the Pong match sequencer: state codes, winner codes
// and the per-state engine control word.
package pong_match_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GOAL  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_PLY1 = 2'd1;
  localparam logic [1:0] WIN_PLY2 = 2'd2;

  typedef struct packed {
    logic game_reset;
    logic game_run;
    logic reset_goals;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{game_reset: 1'b1, game_run: 1'b0, reset_goals: 1'b1};

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the match sequencer and its surroundings
// (button/engine inputs, engine control and score display outputs).
interface pong_match_ctrl_if;
  logic       start_btn;
  logic       goal_ply1;
  logic       goal_ply2;
  logic       game_reset;
  logic       game_run;
  logic       reset_goals;
  logic [3:0] score_ply1;
  logic [3:0] score_ply2;
  logic [1:0] winner;
  logic [2:0] state;

  modport master (
    output start_btn, goal_ply1, goal_ply2,
    input  game_reset, game_run, reset_goals, score_ply1, score_ply2, winner, state
  );

  modport slave (
    input  start_btn, goal_ply1, goal_ply2,
    output game_reset, game_run, reset_goals, score_ply1, score_ply2, winner, state
  );
endinterface

// File: rtl/pong_btn_sync.sv
// Two-flop synchroniser for an asynchronous button followed by a
// rising-edge detector producing a one-cycle pulse.
module pong_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign pulse = sync_p1 & ~prev_p2;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: serve delay, goal counting, pause and game-over control
// of the ball engine, with scores and state for the score display.
module pong_match_ctrl
  import pong_match_ctrl_pkg::*;
#(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 60,
  parameter int GOAL_TICKS  = 30,
  parameter int TMR_W       = 8
) (
  input  logic            dyn_clk,
  input  logic            reset,
  pong_match_ctrl_if.slave bus
);

  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
  localparam logic [TMR_W-1:0] SERVE_LOAD = TMR_W'(SERVE_TICKS - 1);
  localparam logic [TMR_W-1:0] GOAL_LOAD  = TMR_W'(GOAL_TICKS - 1);

  state_t           state_q, state_d;
  ctrl_t            ctrl_d, ctrl_q;
  logic [TMR_W-1:0] timer;
  logic [3:0]       score1, score2;
  logic [3:0]       score1_inc, score2_inc;
  logic [1:0]       winner_q;
  logic             start_p;
  logic             g1_prev, g2_prev;
  logic             g1_edge, g2_edge;
  logic             g1_cnt, g2_cnt;

  pong_btn_sync u_start_sync (
    .clk   (dyn_clk),
    .rst   (reset),
    .btn   (bus.start_btn),
    .pulse (start_p)
  );

  assign g1_edge    = bus.goal_ply1 & ~g1_prev;
  assign g2_edge    = bus.goal_ply2 & ~g2_prev;
  // Simultaneous goals cancel each other out
  assign g1_cnt     = g1_edge & ~g2_edge;
  assign g2_cnt     = g2_edge & ~g1_edge;
  assign score1_inc = score1 + 4'd1;
  assign score2_inc = score2 + 4'd1;

  always_ff @(posedge dyn_clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_p) state_d = ST_SERVE;
      ST_SERVE: if (timer == '0) state_d = ST_PLAY;
      ST_PLAY: begin
        if (g1_cnt)       state_d = (score1_inc == WIN) ? ST_OVER : ST_GOAL;
        else if (g2_cnt)  state_d = (score2_inc == WIN) ? ST_OVER : ST_GOAL;
        else if (start_p) state_d = ST_PAUSE;
      end
      ST_GOAL:  if (timer == '0) state_d = ST_SERVE;
      ST_PAUSE: if (start_p) state_d = ST_PLAY;
      ST_OVER:  if (start_p) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d = CTRL_IDLE;
    case (state_q)
      ST_SERVE: ctrl_d = '{game_reset: 1'b1, game_run: 1'b0, reset_goals: 1'b0};
      ST_PLAY:  ctrl_d = '{game_reset: 1'b0, game_run: 1'b1, reset_goals: 1'b0};
      ST_GOAL,
      ST_PAUSE,
      ST_OVER:  ctrl_d = '{game_reset: 1'b0, game_run: 1'b0, reset_goals: 1'b0};
      default:  ctrl_d = CTRL_IDLE;
    endcase
  end

  // Engine controls are registered, so they follow the state by one clock
  always_ff @(posedge dyn_clk or posedge reset) begin
    if (reset) ctrl_q <= CTRL_IDLE;
    else       ctrl_q <= ctrl_d;
  end

  always_ff @(posedge dyn_clk or posedge reset) begin
    if (reset) begin
      g1_prev <= 1'b0;
      g2_prev <= 1'b0;
    end else begin
      g1_prev <= bus.goal_ply1;
      g2_prev <= bus.goal_ply2;
    end
  end

  always_ff @(posedge dyn_clk or posedge reset) begin
    if (reset) begin
      score1   <= '0;
      score2   <= '0;
      winner_q <= WIN_NONE;
      timer    <= '0;
    end else begin
      if (state_q == ST_IDLE || (state_q == ST_OVER && start_p)) begin
        score1   <= '0;
        score2   <= '0;
        winner_q <= WIN_NONE;
      end else if (state_q == ST_PLAY) begin
        if (g1_cnt) score1 <= score1_inc;
        if (g2_cnt) score2 <= score2_inc;
        if (state_d == ST_OVER) winner_q <= g1_cnt ? WIN_PLY1 : WIN_PLY2;
      end

      if (state_d == ST_SERVE && state_q != ST_SERVE)
        timer <= SERVE_LOAD;
      else if (state_d == ST_GOAL && state_q == ST_PLAY)
        timer <= GOAL_LOAD;
      else if ((state_q == ST_SERVE || state_q == ST_GOAL) && timer != '0)
        timer <= timer - TMR_W'(1);
    end
  end

  assign bus.game_reset  = ctrl_q.game_reset;
  assign bus.game_run    = ctrl_q.game_run;
  assign bus.reset_goals = ctrl_q.reset_goals;
  assign bus.score_ply1  = score1;
  assign bus.score_ply2  = score2;
  assign bus.winner      = winner_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scenario bench for pong_match_ctrl: directed match phases plus randomized
// matches scored against a simple score/winner model.
module tb_pong_match_ctrl;

  localparam int WIN = 3;
  localparam int SRV = 4;
  localparam int GL  = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_GOAL  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  logic dyn_clk = 1'b0;
  logic reset   = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   sc [2];

  pong_match_ctrl_if bus ();

  pong_match_ctrl #(
    .WIN_SCORE   (WIN),
    .SERVE_TICKS (SRV),
    .GOAL_TICKS  (GL),
    .TMR_W       (8)
  ) dut (
    .dyn_clk (dyn_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 dyn_clk = ~dyn_clk;

  // One clock; outputs sampled 1 time unit after the edge, with the
  // always-true match invariants checked on every sample.
  task automatic tick();
    @(posedge dyn_clk);
    #1;
    if (!reset) begin
      vectors++;
      if ((bus.game_run && bus.game_reset) || bus.score_ply1 > 4'(WIN) || bus.score_ply2 > 4'(WIN)) begin
        miscompares++;
        $display("FAIL invariant: run=%0b reset=%0b s1=%0d s2=%0d", bus.game_run, bus.game_reset,
                 bus.score_ply1, bus.score_ply2);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_start();
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (bus.state !== s && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (bus.state !== s) begin
      miscompares++;
      $display("FAIL %s: state=%0d want %0d after %0d clocks", name, bus.state, s, n);
    end
  endtask

  task automatic do_reset();
    bus.start_btn = 1'b0;
    bus.goal_ply1 = 1'b0;
    bus.goal_ply2 = 1'b0;
    #2 reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.state !== S_IDLE) begin
      miscompares++; $display("FAIL reset_state: got %0d want %0d", bus.state, S_IDLE);
    end
    vectors++;
    if ({bus.game_reset, bus.game_run, bus.reset_goals} !== 3'b101) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 101", {bus.game_reset, bus.game_run, bus.reset_goals});
    end
    vectors++;
    if ({bus.score_ply1, bus.score_ply2, bus.winner} !== 10'd0) begin
      miscompares++; $display("FAIL reset_scores: got %0d/%0d/%0d want 0/0/0", bus.score_ply1, bus.score_ply2, bus.winner);
    end
  endtask

  task automatic test_start_serve();
    press_start();
    tick();
    vectors++;
    if (bus.state !== S_IDLE) begin
      miscompares++; $display("FAIL start_latency_early: state=%0d want %0d", bus.state, S_IDLE);
    end
    tick();
    vectors++;
    if (bus.state !== S_SERVE) begin
      miscompares++; $display("FAIL start_to_serve: state=%0d want %0d", bus.state, S_SERVE);
    end
    for (int k = 0; k < SRV - 1; k++) begin
      tick();
      vectors++;
      if (bus.state !== S_SERVE || bus.game_reset !== 1'b1) begin
        miscompares++; $display("FAIL serve_hold%0d: state=%0d reset=%0b want %0d/1", k, bus.state, bus.game_reset, S_SERVE);
      end
    end
    tick();
    vectors++;
    if (bus.state !== S_PLAY || bus.game_reset !== 1'b1 || bus.game_run !== 1'b0) begin
      miscompares++; $display("FAIL serve_to_play: state=%0d reset=%0b run=%0b want %0d/1/0", bus.state, bus.game_reset, bus.game_run, S_PLAY);
    end
    tick();
    vectors++;
    if (bus.game_run !== 1'b1 || bus.game_reset !== 1'b0) begin
      miscompares++; $display("FAIL play_ctrl: run=%0b reset=%0b want 1/0", bus.game_run, bus.game_reset);
    end
  endtask

  task automatic test_goal_hold();
    bus.goal_ply1 = 1'b1;
    tick();
    vectors++;
    if (bus.score_ply1 !== 4'd1 || bus.state !== S_GOAL) begin
      miscompares++; $display("FAIL goal_count: s1=%0d state=%0d want 1/%0d", bus.score_ply1, bus.state, S_GOAL);
    end
    tick();
    vectors++;
    if (bus.state !== S_GOAL || bus.game_run !== 1'b0) begin
      miscompares++; $display("FAIL goal_hold: state=%0d run=%0b want %0d/0", bus.state, bus.game_run, S_GOAL);
    end
    tick();
    bus.goal_ply1 = 1'b0;
    vectors++;
    if (bus.state !== S_SERVE) begin
      miscompares++; $display("FAIL goal_to_serve: state=%0d want %0d", bus.state, S_SERVE);
    end
    ticks(SRV - 1);
    vectors++;
    if (bus.state !== S_SERVE) begin
      miscompares++; $display("FAIL goal_serve_len: state=%0d want %0d", bus.state, S_SERVE);
    end
    tick();
    vectors++;
    if (bus.state !== S_PLAY || bus.score_ply1 !== 4'd1) begin
      miscompares++; $display("FAIL goal_once: state=%0d s1=%0d want %0d/1", bus.state, bus.score_ply1, S_PLAY);
    end
  endtask

  task automatic test_both_and_pause();
    bus.goal_ply1 = 1'b1;
    bus.goal_ply2 = 1'b1;
    tick();
    vectors++;
    if (bus.state !== S_PLAY || bus.score_ply1 !== 4'd1 || bus.score_ply2 !== 4'd0) begin
      miscompares++; $display("FAIL both_goals: state=%0d s=%0d:%0d want %0d 1:0", bus.state, bus.score_ply1, bus.score_ply2, S_PLAY);
    end
    bus.goal_ply1 = 1'b0;
    bus.goal_ply2 = 1'b0;
    tick();
    press_start();
    ticks(2);
    vectors++;
    if (bus.state !== S_PAUSE) begin
      miscompares++; $display("FAIL pause_enter: state=%0d want %0d", bus.state, S_PAUSE);
    end
    bus.goal_ply2 = 1'b1;
    tick();
    bus.goal_ply2 = 1'b0;
    tick();
    vectors++;
    if (bus.score_ply2 !== 4'd0 || bus.state !== S_PAUSE) begin
      miscompares++; $display("FAIL pause_goal: s2=%0d state=%0d want 0/%0d", bus.score_ply2, bus.state, S_PAUSE);
    end
    press_start();
    ticks(2);
    vectors++;
    if (bus.state !== S_PLAY) begin
      miscompares++; $display("FAIL pause_resume: state=%0d want %0d", bus.state, S_PLAY);
    end
  endtask

  task automatic test_win_p2();
    for (int g = 1; g <= WIN; g++) begin
      wait_state(S_PLAY, 20, "win_wait_play");
      bus.goal_ply2 = 1'b1;
      tick();
      bus.goal_ply2 = 1'b0;
      vectors++;
      if (bus.score_ply2 !== 4'(g)) begin
        miscompares++; $display("FAIL win_score%0d: s2=%0d want %0d", g, bus.score_ply2, g);
      end
    end
    vectors++;
    if (bus.state !== S_OVER || bus.winner !== 2'd2) begin
      miscompares++; $display("FAIL win_over: state=%0d winner=%0d want %0d/2", bus.state, bus.winner, S_OVER);
    end
    tick();
    vectors++;
    if (bus.game_run !== 1'b0 || bus.score_ply2 !== 4'd3) begin
      miscompares++; $display("FAIL win_hold: run=%0b s2=%0d want 0/3", bus.game_run, bus.score_ply2);
    end
    press_start();
    ticks(2);
    vectors++;
    if (bus.state !== S_IDLE || bus.score_ply1 !== 4'd0 || bus.score_ply2 !== 4'd0 || bus.winner !== 2'd0) begin
      miscompares++; $display("FAIL over_to_idle: state=%0d s=%0d:%0d w=%0d want %0d 0:0 0", bus.state, bus.score_ply1, bus.score_ply2, bus.winner, S_IDLE);
    end
    tick();
    vectors++;
    if (bus.reset_goals !== 1'b1) begin
      miscompares++; $display("FAIL idle_reset_goals: got %0b want 1", bus.reset_goals);
    end
  endtask

  task automatic test_goal_with_start();
    press_start();
    wait_state(S_PLAY, 20, "gws_wait_play");
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    tick();
    bus.goal_ply1 = 1'b1;
    tick();
    bus.goal_ply1 = 1'b0;
    vectors++;
    if (bus.state !== S_GOAL || bus.score_ply1 !== 4'd1) begin
      miscompares++; $display("FAIL goal_beats_start: state=%0d s1=%0d want %0d/1", bus.state, bus.score_ply1, S_GOAL);
    end
    wait_state(S_PLAY, 20, "gws_back_play");
    press_start();
    ticks(2);
    vectors++;
    if (bus.state !== S_PAUSE) begin
      miscompares++; $display("FAIL gws_pause: state=%0d want %0d", bus.state, S_PAUSE);
    end
    press_start();
    ticks(2);
    vectors++;
    if (bus.state !== S_PLAY) begin
      miscompares++; $display("FAIL gws_resume: state=%0d want %0d", bus.state, S_PLAY);
    end
  endtask

  task automatic test_async_reset();
    bus.goal_ply1 = 1'b1;
    tick();
    bus.goal_ply1 = 1'b0;
    wait_state(S_PLAY, 20, "ar_wait_play");
    bus.goal_ply2 = 1'b1;
    tick();
    bus.goal_ply2 = 1'b0;
    wait_state(S_SERVE, 20, "ar_wait_serve");
    tick();
    vectors++;
    if (bus.state !== S_SERVE || bus.score_ply1 !== 4'd2 || bus.score_ply2 !== 4'd1) begin
      miscompares++; $display("FAIL ar_setup: state=%0d s=%0d:%0d want %0d 2:1", bus.state, bus.score_ply1, bus.score_ply2, S_SERVE);
    end
    #1 reset = 1'b1;
    #2;
    vectors++;
    if (bus.state !== S_IDLE || {bus.game_reset, bus.game_run, bus.reset_goals} !== 3'b101 ||
        bus.score_ply1 !== 4'd0 || bus.score_ply2 !== 4'd0 || bus.winner !== 2'd0) begin
      miscompares++; $display("FAIL async_reset: state=%0d ctrl=%b s=%0d:%0d want %0d 101 0:0",
                              bus.state, {bus.game_reset, bus.game_run, bus.reset_goals}, bus.score_ply1, bus.score_ply2, S_IDLE);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random_matches();
    for (int m = 0; m < 6; m++) begin
      do_reset();
      press_start();
      sc[0] = 0;
      sc[1] = 0;
      for (int e = 0; e < 40; e++) begin
        int kind;
        int p;
        int hold;
        wait_state(S_PLAY, 30, "rnd_wait_play");
        if (bus.state !== S_PLAY) break;
        ticks($urandom_range(0, 3));
        kind = $urandom_range(0, 5);
        if (kind <= 2) begin
          p = $urandom_range(0, 1);
          hold = $urandom_range(1, 3);
          if (p == 0) bus.goal_ply1 = 1'b1; else bus.goal_ply2 = 1'b1;
          tick();
          sc[p]++;
          vectors++;
          if (bus.score_ply1 !== 4'(sc[0]) || bus.score_ply2 !== 4'(sc[1])) begin
            miscompares++; $display("FAIL rnd_score: got %0d:%0d want %0d:%0d", bus.score_ply1, bus.score_ply2, sc[0], sc[1]);
          end
          vectors++;
          if (bus.state !== ((sc[p] == WIN) ? S_OVER : S_GOAL)) begin
            miscompares++; $display("FAIL rnd_after_goal: state=%0d want %0d", bus.state, (sc[p] == WIN) ? S_OVER : S_GOAL);
          end
          ticks(hold - 1);
          bus.goal_ply1 = 1'b0;
          bus.goal_ply2 = 1'b0;
          if (sc[p] == WIN) begin
            tick();
            vectors++;
            if (bus.winner !== 2'(p + 1) || bus.game_run !== 1'b0) begin
              miscompares++; $display("FAIL rnd_winner: winner=%0d run=%0b want %0d/0", bus.winner, bus.game_run, p + 1);
            end
            break;
          end
        end else if (kind == 3) begin
          bus.goal_ply1 = 1'b1;
          bus.goal_ply2 = 1'b1;
          tick();
          vectors++;
          if (bus.state !== S_PLAY || bus.score_ply1 !== 4'(sc[0]) || bus.score_ply2 !== 4'(sc[1])) begin
            miscompares++; $display("FAIL rnd_both: state=%0d s=%0d:%0d want %0d %0d:%0d", bus.state, bus.score_ply1, bus.score_ply2, S_PLAY, sc[0], sc[1]);
          end
          bus.goal_ply1 = 1'b0;
          bus.goal_ply2 = 1'b0;
          tick();
        end else begin
          press_start();
          ticks(2);
          vectors++;
          if (bus.state !== S_PAUSE) begin
            miscompares++; $display("FAIL rnd_pause: state=%0d want %0d", bus.state, S_PAUSE);
          end
          if ($urandom_range(0, 1) == 0) bus.goal_ply1 = 1'b1; else bus.goal_ply2 = 1'b1;
          tick();
          bus.goal_ply1 = 1'b0;
          bus.goal_ply2 = 1'b0;
          press_start();
          ticks(2);
          vectors++;
          if (bus.state !== S_PLAY || bus.score_ply1 !== 4'(sc[0]) || bus.score_ply2 !== 4'(sc[1])) begin
            miscompares++; $display("FAIL rnd_resume: state=%0d s=%0d:%0d want %0d %0d:%0d", bus.state, bus.score_ply1, bus.score_ply2, S_PLAY, sc[0], sc[1]);
          end
        end
      end
    end
  endtask

  initial begin
    bus.start_btn = 1'b0;
    bus.goal_ply1 = 1'b0;
    bus.goal_ply2 = 1'b0;
    test_reset();
    test_start_serve();
    test_goal_hold();
    test_both_and_pause();
    test_win_p2();
    test_goal_with_start();
    test_async_reset();
    test_random_matches();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
